// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the core and a loader, with registered read return.
// Optional MEM_ARB_STARVE_EN: starvation timer that breaks a loader burst lock after MAX_WAIT cycles.
module mem_arbiter #(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    input  logic          l_lock,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [DW-1:0] l_rdata,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          starve
);

    if (MAX_WAIT < 2) begin : g_bad_param
        $error("mem_arbiter: MAX_WAIT must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, CORE, LDR} state_t;

    state_t state;
    state_t state_nxt;
    logic   prio;
    logic   c_acc;
    logic   l_acc;
    logic   brk;

    assign c_gnt = (state == CORE);
    assign l_gnt = (state == LDR);

    // Reset masks accesses so a write in flight at reset never reaches memory.
    assign c_acc = c_gnt && c_req && !rst;
    assign l_acc = l_gnt && l_req && !rst;

`ifdef MEM_ARB_STARVE_EN
    localparam int CW = $clog2(MAX_WAIT) + 1;
    logic [CW-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (c_gnt || !c_req) begin
            wait_cnt <= '0;
        end else if (wait_cnt != {CW{1'b1}}) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign brk    = c_req && !c_gnt && (wait_cnt == CW'(MAX_WAIT - 1));
    assign starve = brk && l_gnt && l_req && l_lock && !rst;
`else
    assign brk    = 1'b0;
    assign starve = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        m_we      = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        if (c_acc) begin
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (l_acc) begin
            m_we    = l_we;
            m_addr  = l_addr;
            m_wdata = l_wdata;
        end
        case (state)
            IDLE: begin
                if (c_req && l_req) state_nxt = prio ? CORE : LDR;
                else if (c_req)     state_nxt = CORE;
                else if (l_req)     state_nxt = LDR;
                else                state_nxt = IDLE;
            end
            CORE: begin
                if (l_req)      state_nxt = LDR;
                else if (c_req) state_nxt = CORE;
                else            state_nxt = IDLE;
            end
            LDR: begin
                if (l_req && l_lock && !brk) state_nxt = LDR;
                else if (c_req)              state_nxt = CORE;
                else if (l_req)              state_nxt = LDR;
                else                         state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prio     <= 1'b1;
            c_rvalid <= 1'b0;
            l_rvalid <= 1'b0;
            c_rdata  <= '0;
            l_rdata  <= '0;
        end else begin
            state    <= state_nxt;
            c_rvalid <= c_acc && !c_we;
            l_rvalid <= l_acc && !l_we;
            if (c_acc) prio <= 1'b0;
            else if (l_acc) prio <= 1'b1;
            if (c_acc && !c_we) c_rdata <= m_rdata;
            if (l_acc && !l_we) l_rdata <= m_rdata;
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single unified `Memory` between the MIPS core (fetch and data accesses) and a program-loader/debug port. It sits between the requesters and the memory and presents one `we/addr/wdata` port to it. It returns registered read data to whichever side issued the read. Arbitration is per-access round-robin, with an optional loader burst lock protected by a starvation timer.

## Interface
- `DW`, 32, data width
- `AW`, 32, address width
- `MAX_WAIT`, 16, max cycles the core may wait behind a locked loader (≥2)

- `clk` in 1: clock
- `rst` in 1: synchronous, active-high reset
- `c_req` in 1: core requests an access
- `c_we` in 1: core access is a write
- `c_addr` in AW: core address
- `c_wdata` in DW: core write data
- `c_gnt` out 1: core owns memory this cycle
- `c_rvalid` out 1: core read data valid
- `c_rdata` out DW: core read data
- `l_req`, `l_we`, `l_addr`, `l_wdata`: loader equivalents of the core inputs
- `l_lock` in 1: loader requests to keep the grant
- `l_gnt`, `l_rvalid`, `l_rdata`: loader equivalents of the core outputs
- `m_we` out 1: memory write enable
- `m_addr` out AW: memory address
- `m_wdata` out DW: memory write data
- `m_rdata` in DW: memory read data, combinational from `m_addr`
- `starve` out 1: one-cycle pulse when a loader lock is broken

## Operation
- The FSM has three states: `IDLE`, `CORE`, `LDR`. `c_gnt` = (state==CORE). `l_gnt` = (state==LDR). Both are registered.
- An access occurs in any cycle where `X_gnt && X_req`. In that cycle `m_addr/m_wdata` = X's signals and `m_we = X_we && !rst`.
- When no access occurs: `m_we=0`, `m_addr=0`, `m_wdata=0`.
- A read access captures `m_rdata` into `X_rdata` at the clock edge. `X_rvalid` is high for exactly the next cycle. `X_rdata` holds its value until the next read by X.
- A write commits at the access edge. Writes produce no `rvalid`.
- A priority bit `prio` records the last side served (0=core, 1=loader). It resets to 1, so the core wins the first tie.
- Next-state rules:
  - From `IDLE`: if both sides request, go to the side opposite `prio`. If only one requests, go to that side. Otherwise stay in `IDLE`.
  - From `CORE`: if `l_req`, go to `LDR`. Else if `c_req`, stay in `CORE`. Else go to `IDLE`.
  - From `LDR`: if `l_req && l_lock && !brk`, stay in `LDR`. Else if `c_req`, go to `CORE`. Else if `l_req`, stay in `LDR`. Else go to `IDLE`.
- `prio` updates to the side that performed an access in the cycle.
- `brk` is the starvation break condition (see Configuration). When the feature is compiled out, `brk=0`.
- The core is never allowed to lock. `c_lock` does not exist.

## Timing
- Latency: request seen at cycle N (from `IDLE`) → `gnt` at N+1 → access at N+1 → `rvalid` at N+2.
- When a requester is already granted, back-to-back accesses run at one per cycle.
- With both sides requesting and no lock, grants alternate every cycle.
- A requester must keep `req`/`addr`/`we`/`wdata` stable until it sees its own `gnt`. Dropping `req` while granted wastes that grant cycle; no access occurs.
- Reset: state=`IDLE`, `prio=1`, all `gnt`/`rvalid`/`starve`=0, `rdata`=0, wait counter=0, `m_*`=0.
- Reset mid-operation: no write is issued in the reset cycle. Any pending `rvalid` is dropped.
- Simultaneous `rst` and request: `rst` wins.

## Configuration
- Macro: `MEM_ARB_STARVE_EN`.
- Defined:
  - A `$clog2(MAX_WAIT)+1`-bit counter `wait_cnt` increments each cycle that `c_req && !c_gnt`. It clears when `c_gnt` or `!c_req`, and saturates.
  - `brk = c_req && !c_gnt && (wait_cnt == MAX_WAIT-1)`.
  - `starve` pulses for one cycle in the cycle the FSM moves from `LDR` to `CORE` due to `brk` while `l_lock` is high.
- Undefined:
  - No counter. `brk=0`, `starve` is tied to 0.
  - `l_lock` is honoured indefinitely, and the core can starve.

## Test plan
- Reset: hold `rst` for 2 cycles with both `req` high → `c_gnt=l_gnt=0`, `m_we=0`, `rvalid=0` throughout; `c_gnt=1` on the first cycle after reset release + 1.
- Core read alone: `c_req`, `c_addr=0x10`, mem[0x10]=0xDEADBEEF at cycle 0 → `c_gnt=1` at cycle 1, `c_rvalid=1` with `c_rdata=0xDEADBEEF` at cycle 2, `l_rvalid=0`.
- Contention without lock: both `req` held high, reads from 0x0/0x4 → grant sequence C,L,C,L,…; each side's `rvalid` alternates; no access is lost.
- Loader locked burst: `l_lock=1`, 4 writes 0x100..0x10C of 1..4 while `c_req` is high → `l_gnt` for 4 consecutive cycles, memory holds 1..4, then `c_gnt` the cycle after `l_req` drops.
- Starvation (`MEM_ARB_STARVE_EN`, `MAX_WAIT=16`): loader locked forever, `c_req` raised at cycle 0 while in `LDR` → `c_gnt=1` at cycle 16, `starve=1` at cycle 15 only. Without the macro → `c_gnt` stays 0 for 100 cycles.
- Reset during loader write: `rst=1` in a cycle with `l_gnt && l_we`, addr 0x20, data 0x55 → `m_we=0`, mem[0x20] unchanged, `l_gnt=0` next cycle.
